// File: rtl/pgen_pkg.sv
// Shared encodings and helpers for the pgen_multi pattern generator.
// Optional gamma stage is enabled by defining PGEN_GAMMA_EN.
package pgen_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_HGRAD = 2'd1,
        MODE_VGRAD = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        StWaitRow,
        StGen,
        StFlush,
        StStore,
        StSwap,
        StNext,
        StWaitFrame
    } state_e;

`ifdef PGEN_GAMMA_EN
    localparam int unsigned PIX_LATENCY = 2;
`else
    localparam int unsigned PIX_LATENCY = 1;
`endif

    // Stretch or squeeze a src_w-bit ramp position onto a dst_w-bit intensity.
    function automatic logic [31:0] scale_pos(input logic [31:0] pos,
                                              input int unsigned src_w,
                                              input int unsigned dst_w);
        if (dst_w >= src_w) begin
            return pos << (dst_w - src_w);
        end
        return pos >> (src_w - dst_w);
    endfunction

endpackage

// File: rtl/pgen_pixel.sv
// One-pixel pattern function with its output pipeline; data, column and strobe stay aligned.
// With PGEN_GAMMA_EN a second registered stage applies v' = (v*v) >> N_PLANES per channel.
module pgen_pixel
    import pgen_pkg::*;
#(
    parameter int unsigned N_COLS       = 64,
    parameter int unsigned N_ROWS       = 32,
    parameter int unsigned N_CHANS      = 3,
    parameter int unsigned N_PLANES     = 8,
    parameter int unsigned N_FRAME_BITS = 8,
    localparam int unsigned COL_W = $clog2(N_COLS),
    localparam int unsigned ROW_W = $clog2(N_ROWS),
    localparam int unsigned PIX_W = N_CHANS * N_PLANES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_i,
    input  logic [COL_W-1:0]        col_i,
    input  logic [ROW_W-1:0]        row_i,
    input  logic [N_FRAME_BITS-1:0] ofs_i,
    input  mode_e                   mode_i,
    input  logic [PIX_W-1:0]        color_i,
    input  logic [N_CHANS-1:0]      mask_i,
    output logic [PIX_W-1:0]        data_o,
    output logic [COL_W-1:0]        col_o,
    output logic                    wren_o
);

    logic [31:0]      col_ext, row_ext, ofs_ext, hpos, vpos, hval, vval;
    logic             chk;
    logic [PIX_W-1:0] pix_d, s1_data_q;
    logic [COL_W-1:0] s1_col_q;
    logic             s1_wren_q;

    always_comb begin
        col_ext = 32'(col_i);
        row_ext = 32'(row_i);
        ofs_ext = 32'(ofs_i);
        hpos    = (col_ext + ofs_ext) % N_COLS;
        vpos    = (row_ext + ofs_ext) % N_ROWS;
        hval    = scale_pos(hpos, COL_W, N_PLANES);
        vval    = scale_pos(vpos, ROW_W, N_PLANES);
        chk     = col_ext[3] ^ row_ext[3] ^ ofs_ext[3];
        pix_d   = '0;
        for (int c = 0; c < N_CHANS; c++) begin
            unique case (mode_i)
                MODE_SOLID: pix_d[c*N_PLANES +: N_PLANES] = color_i[c*N_PLANES +: N_PLANES];
                MODE_HGRAD: pix_d[c*N_PLANES +: N_PLANES] = hval[N_PLANES-1:0];
                MODE_VGRAD: pix_d[c*N_PLANES +: N_PLANES] = vval[N_PLANES-1:0];
                MODE_CHECK: pix_d[c*N_PLANES +: N_PLANES] =
                    chk ? color_i[c*N_PLANES +: N_PLANES] : '0;
                default:    pix_d[c*N_PLANES +: N_PLANES] = '0;
            endcase
            if (!mask_i[c]) begin
                pix_d[c*N_PLANES +: N_PLANES] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q <= '0;
            s1_col_q  <= '0;
            s1_wren_q <= 1'b0;
        end else begin
            s1_data_q <= valid_i ? pix_d : '0;
            s1_col_q  <= valid_i ? col_i : '0;
            s1_wren_q <= valid_i;
        end
    end

`ifdef PGEN_GAMMA_EN
    logic [PIX_W-1:0]      gam_d, s2_data_q;
    logic [COL_W-1:0]      s2_col_q;
    logic                  s2_wren_q;
    logic [2*N_PLANES-1:0] sq;

    always_comb begin
        gam_d = '0;
        sq    = '0;
        for (int c = 0; c < N_CHANS; c++) begin
            sq = {{N_PLANES{1'b0}}, s1_data_q[c*N_PLANES +: N_PLANES]} *
                 {{N_PLANES{1'b0}}, s1_data_q[c*N_PLANES +: N_PLANES]};
            gam_d[c*N_PLANES +: N_PLANES] = sq[2*N_PLANES-1:N_PLANES];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_data_q <= '0;
            s2_col_q  <= '0;
            s2_wren_q <= 1'b0;
        end else begin
            s2_data_q <= gam_d;
            s2_col_q  <= s1_col_q;
            s2_wren_q <= s1_wren_q;
        end
    end

    assign data_o = s2_data_q;
    assign col_o  = s2_col_q;
    assign wren_o = s2_wren_q;
`else
    assign data_o = s1_data_q;
    assign col_o  = s1_col_q;
    assign wren_o = s1_wren_q;
`endif

endmodule

// File: rtl/pgen_multi.sv
// Multi-mode test-pattern generator feeding the hub75 frame-buffer write port.
// Define PGEN_GAMMA_EN to add the gamma stage (pixel latency and flush become 2 cycles).
module pgen_multi
    import pgen_pkg::*;
#(
    parameter int unsigned N_BANKS      = 2,
    parameter int unsigned N_ROWS       = 32,
    parameter int unsigned N_COLS       = 64,
    parameter int unsigned N_CHANS      = 3,
    parameter int unsigned N_PLANES     = 8,
    parameter int unsigned N_FRAME_BITS = 8,
    localparam int unsigned ADDR_W = $clog2(N_BANKS * N_ROWS),
    localparam int unsigned ROW_W  = $clog2(N_ROWS),
    localparam int unsigned COL_W  = $clog2(N_COLS),
    localparam int unsigned PIX_W  = N_CHANS * N_PLANES
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  fbw_row_addr_o,
    output logic               fbw_row_store_o,
    input  logic               fbw_row_rdy_i,
    output logic               fbw_row_swap_o,
    output logic [PIX_W-1:0]   fbw_data_o,
    output logic [COL_W-1:0]   fbw_col_addr_o,
    output logic               fbw_wren_o,
    output logic               frame_swap_o,
    input  logic               frame_rdy_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic [PIX_W-1:0]   cfg_color_i,
    input  logic [N_CHANS-1:0] cfg_chan_mask_i,
    input  logic               cfg_anim_i
);

    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(N_BANKS * N_ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(N_COLS - 1);
    localparam logic [1:0]        LAST_FLSH = 2'(PIX_LATENCY - 1);

    state_e                  state_q;
    logic [ADDR_W-1:0]       row_q;
    logic [COL_W-1:0]        col_q;
    logic [N_FRAME_BITS-1:0] frame_q;
    logic [1:0]              flush_q;
    logic                    store_q, swap_q, fswap_q;
    mode_e                   mode_q;
    logic [N_CHANS-1:0]      mask_q;
    logic                    anim_q;
    logic                    cfg_first_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitRow;
            row_q       <= '0;
            col_q       <= '0;
            frame_q     <= '0;
            flush_q     <= '0;
            store_q     <= 1'b0;
            swap_q      <= 1'b0;
            fswap_q     <= 1'b0;
            mode_q      <= MODE_SOLID;
            mask_q      <= '0;
            anim_q      <= 1'b0;
            cfg_first_q <= 1'b1;
        end else begin
            store_q <= 1'b0;
            swap_q  <= 1'b0;
            fswap_q <= 1'b0;
            // Configuration is only taken at reset release and at frame boundaries.
            if (cfg_first_q) begin
                mode_q      <= mode_e'(cfg_mode_i);
                mask_q      <= cfg_chan_mask_i;
                anim_q      <= cfg_anim_i;
                cfg_first_q <= 1'b0;
            end
            case (state_q)
                StWaitRow: begin
                    if (fbw_row_rdy_i) begin
                        col_q   <= '0;
                        state_q <= StGen;
                    end
                end
                StGen: begin
                    if (col_q == LAST_COL) begin
                        flush_q <= '0;
                        state_q <= StFlush;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                StFlush: begin
                    if (flush_q == LAST_FLSH) begin
                        store_q <= 1'b1;
                        state_q <= StStore;
                    end else begin
                        flush_q <= flush_q + 1'b1;
                    end
                end
                StStore: state_q <= StSwap;
                StSwap: begin
                    if (fbw_row_rdy_i) begin
                        swap_q  <= 1'b1;
                        state_q <= StNext;
                    end
                end
                StNext: begin
                    if (row_q == LAST_ROW) begin
                        state_q <= StWaitFrame;
                    end else begin
                        row_q   <= row_q + 1'b1;
                        state_q <= StWaitRow;
                    end
                end
                StWaitFrame: begin
                    if (frame_rdy_i) begin
                        fswap_q <= 1'b1;
                        frame_q <= frame_q + 1'b1;
                        row_q   <= '0;
                        mode_q  <= mode_e'(cfg_mode_i);
                        mask_q  <= cfg_chan_mask_i;
                        anim_q  <= cfg_anim_i;
                        state_q <= StWaitRow;
                    end
                end
                default: state_q <= StWaitRow;
            endcase
        end
    end

    pgen_pixel #(
        .N_COLS       (N_COLS),
        .N_ROWS       (N_ROWS),
        .N_CHANS      (N_CHANS),
        .N_PLANES     (N_PLANES),
        .N_FRAME_BITS (N_FRAME_BITS)
    ) u_pixel (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (state_q == StGen),
        .col_i   (col_q),
        .row_i   (row_q[ROW_W-1:0]),
        .ofs_i   (anim_q ? frame_q : '0),
        .mode_i  (mode_q),
        .color_i (cfg_color_i),
        .mask_i  (mask_q),
        .data_o  (fbw_data_o),
        .col_o   (fbw_col_addr_o),
        .wren_o  (fbw_wren_o)
    );

    assign fbw_row_addr_o  = row_q;
    assign fbw_row_store_o = store_q;
    assign fbw_row_swap_o  = swap_q;
    assign frame_swap_o    = fswap_q;

endmodule

// File: tb/tb_pgen_multi.sv
// Self-checking bench for pgen_multi: vector table, directed corner sequences and a
// randomized run scored against a frame-level reference model.
module tb_pgen_multi;

    localparam int N_ROWS = 32;
    localparam int N_COLS = 64;
    localparam int N_CHANS = 3;
    localparam int TOTAL_ROWS = 64;
    localparam int PIX_W = 24;

    logic              clk, rst_n;
    logic [5:0]        fbw_row_addr, fbw_col_addr;
    logic              fbw_row_store, fbw_row_rdy, fbw_row_swap, fbw_wren;
    logic              frame_swap, frame_rdy, cfg_anim;
    logic [PIX_W-1:0]  fbw_data, cfg_color;
    logic [1:0]        cfg_mode;
    logic [2:0]        cfg_chan_mask;

    pgen_multi #(
        .N_BANKS (2), .N_ROWS (32), .N_COLS (64), .N_CHANS (3), .N_PLANES (8), .N_FRAME_BITS (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fbw_row_addr_o  (fbw_row_addr),
        .fbw_row_store_o (fbw_row_store),
        .fbw_row_rdy_i   (fbw_row_rdy),
        .fbw_row_swap_o  (fbw_row_swap),
        .fbw_data_o      (fbw_data),
        .fbw_col_addr_o  (fbw_col_addr),
        .fbw_wren_o      (fbw_wren),
        .frame_swap_o    (frame_swap),
        .frame_rdy_i     (frame_rdy),
        .cfg_mode_i      (cfg_mode),
        .cfg_color_i     (cfg_color),
        .cfg_chan_mask_i (cfg_chan_mask),
        .cfg_anim_i      (cfg_anim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int gam(input int v);
`ifdef PGEN_GAMMA_EN
        return (v * v) / 256;
`else
        return v;
`endif
    endfunction

    function automatic logic [PIX_W-1:0] gam_pix(input logic [PIX_W-1:0] p);
        logic [PIX_W-1:0] r;
        r = '0;
        for (int c = 0; c < N_CHANS; c++) r[c*8 +: 8] = 8'(gam(int'(p[c*8 +: 8])));
        return r;
    endfunction

    // Expected pixel straight from the pattern rules.
    function automatic logic [PIX_W-1:0] ref_pix(input int mode, input logic [PIX_W-1:0] color,
                                                 input logic [2:0] mask, input bit anim,
                                                 input int frame, input int row, input int col);
        int o, r, v, par;
        logic [PIX_W-1:0] res;
        o = anim ? (frame % 256) : 0;
        r = row % N_ROWS;
        res = '0;
        for (int c = 0; c < N_CHANS; c++) begin
            case (mode)
                0: v = int'(color[c*8 +: 8]);
                1: v = ((col + o) % N_COLS) * (256 / N_COLS);
                2: v = ((r + o) % N_ROWS) * (256 / N_ROWS);
                default: begin
                    par = ((col / 8) % 2 + (r / 8) % 2 + (o / 8) % 2) % 2;
                    v = (par == 1) ? int'(color[c*8 +: 8]) : 0;
                end
            endcase
            v = gam(v);
            if (!mask[c]) v = 0;
            res[c*8 +: 8] = 8'(v);
        end
        return res;
    endfunction

    // Config as seen by the DUT at the most recent rising edge.
    logic [1:0] sh_mode;
    logic [2:0] sh_mask;
    logic       sh_anim;
    always @(posedge clk) begin
        sh_mode <= cfg_mode;
        sh_mask <= cfg_chan_mask;
        sh_anim <= cfg_anim;
    end

    // Frame-level scoreboard: which row/column should appear next and what it holds.
    int m_row, m_col, m_frame, m_mode;
    bit m_first, m_stored, m_frame_due, m_anim;
    logic [2:0] m_mask;

    always @(negedge clk) begin : monitor
        int npulse;
        if (!rst_n) begin
            m_row = 0; m_col = 0; m_frame = 0;
            m_first = 1'b1; m_stored = 1'b0; m_frame_due = 1'b0;
        end else begin
            if (m_first) begin
                m_mode = int'(sh_mode); m_mask = sh_mask; m_anim = sh_anim; m_first = 1'b0;
            end
            npulse = int'(fbw_row_store) + int'(fbw_row_swap) + int'(frame_swap);
            check("pulse_exclusive", 32'(npulse <= 1), 32'd1);
            if (fbw_wren) begin
                check("wren_in_row", 32'(m_col < N_COLS && !m_frame_due), 32'd1);
                check("wren_col", 32'(fbw_col_addr), 32'(m_col));
                check("wren_row", 32'(fbw_row_addr), 32'(m_row));
                check("wren_data", 32'(fbw_data),
                      32'(ref_pix(m_mode, cfg_color, m_mask, m_anim, m_frame, m_row, m_col)));
                m_col++;
            end
            if (fbw_row_store) begin
                check("store_after_row", 32'(m_col == N_COLS && !m_stored), 32'd1);
                check("store_row_addr", 32'(fbw_row_addr), 32'(m_row));
                m_stored = 1'b1;
            end
            if (fbw_row_swap) begin
                check("swap_after_store", 32'(m_stored), 32'd1);
                check("swap_row_addr", 32'(fbw_row_addr), 32'(m_row));
                m_stored = 1'b0;
                m_col = 0;
                if (m_row == TOTAL_ROWS - 1) m_frame_due = 1'b1;
                else m_row++;
            end
            if (frame_swap) begin
                check("frame_swap_after_last", 32'(m_frame_due), 32'd1);
                m_frame_due = 1'b0;
                m_row = 0;
                m_frame++;
                m_mode = int'(sh_mode); m_mask = sh_mask; m_anim = sh_anim;
            end
        end
    end

    task automatic do_reset(input int mode, input logic [PIX_W-1:0] color,
                            input logic [2:0] mask, input bit anim);
        @(negedge clk); #1;
        rst_n = 1'b0;
        cfg_mode = 2'(mode); cfg_color = color; cfg_chan_mask = mask; cfg_anim = anim;
        fbw_row_rdy = 1'b1; frame_rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_pixel(input int row, input int col, output logic [PIX_W-1:0] d);
        bit ok;
        ok = 1'b0;
        d = '0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (fbw_wren && int'(fbw_row_addr) == row && int'(fbw_col_addr) == col) begin
                d = fbw_data; ok = 1'b1; break;
            end
        end
        check($sformatf("reach_r%0d_c%0d", row, col), 32'(ok), 32'd1);
    endtask

    task automatic wait_frame();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (frame_swap) begin ok = 1'b1; break; end
        end
        check("reach_frame_swap", 32'(ok), 32'd1);
    endtask

    typedef struct {
        int               mode;
        logic [PIX_W-1:0] color;
        logic [2:0]       mask;
        int               row;
        int               col;
        logic [PIX_W-1:0] exp;
    } vec_t;
    vec_t vecs[12];

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [PIX_W-1:0] d;
        logic [5:0] held_addr;
        int wcount, frames;
        bit got;

        vecs[0]  = '{1, 24'h000000, 3'b111, 0, 0, 24'h000000};
        vecs[1]  = '{1, 24'h000000, 3'b111, 0, 5, 24'h141414};
        vecs[2]  = '{1, 24'h000000, 3'b111, 0, 63, 24'hFCFCFC};
        vecs[3]  = '{0, 24'h102030, 3'b101, 3, 7, 24'h100030};
        vecs[4]  = '{0, 24'hABCDEF, 3'b010, 1, 40, 24'h00CD00};
        vecs[5]  = '{2, 24'h000000, 3'b111, 7, 9, 24'h383838};
        vecs[6]  = '{2, 24'h000000, 3'b111, 39, 0, 24'h383838};
        vecs[7]  = '{3, 24'h123456, 3'b111, 0, 8, 24'h123456};
        vecs[8]  = '{3, 24'h123456, 3'b111, 0, 3, 24'h000000};
        vecs[9]  = '{3, 24'h123456, 3'b111, 9, 9, 24'h000000};
        vecs[10] = '{3, 24'h123456, 3'b111, 9, 0, 24'h123456};
        vecs[11] = '{1, 24'h000000, 3'b001, 2, 10, 24'h000028};

        rst_n = 1'b0; fbw_row_rdy = 1'b1; frame_rdy = 1'b1;
        cfg_mode = 2'd1; cfg_color = '0; cfg_chan_mask = 3'b111; cfg_anim = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(fbw_data), 32'd0);
        check("reset_ctrl", {20'd0, fbw_row_addr, fbw_col_addr},  32'd0);
        check("reset_pulses", {28'd0, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap}, 32'd0);

        // Row 0 of a horizontal gradient: 64 writes, then store, then swap.
        #1 rst_n = 1'b1;
        wcount = 0; got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fbw_wren) wcount++;
            if (fbw_row_store) begin got = 1'b1; break; end
        end
        check("row0_store_seen", 32'(got), 32'd1);
        check("row0_wren_count", 32'(wcount), 32'd64);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (fbw_row_swap) begin got = 1'b1; break; end
        end
        check("row0_swap_seen", 32'(got), 32'd1);
        wait_frame();

        for (int i = 0; i < 12; i++) begin
            do_reset(vecs[i].mode, vecs[i].color, vecs[i].mask, 1'b0);
            wait_pixel(vecs[i].row, vecs[i].col, d);
            check($sformatf("vec%0d", i), 32'(d), 32'(gam_pix(vecs[i].exp)));
        end

        // Row buffer held busy in SWAP.
        do_reset(1, 24'h0, 3'b111, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fbw_row_store) begin got = 1'b1; break; end
        end
        check("stall_store_seen", 32'(got), 32'd1);
        #1 fbw_row_rdy = 1'b0;
        held_addr = fbw_row_addr;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_no_swap", 32'(fbw_row_swap), 32'd0);
            check("stall_addr_held", 32'(fbw_row_addr), 32'(held_addr));
        end
        #1 fbw_row_rdy = 1'b1;
        @(negedge clk);
        check("stall_swap_after_release", 32'(fbw_row_swap), 32'd1);

        // Reset in the middle of row 5 of the second frame.
        do_reset(1, 24'h0, 3'b111, 1'b1);
        wait_frame();
        wait_pixel(5, 20, d);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_data", 32'(fbw_data), 32'd0);
        check("midreset_ctrl", {20'd0, fbw_row_addr, fbw_col_addr}, 32'd0);
        check("midreset_pulses", {28'd0, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        got = 1'b0; wcount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            wcount += int'(fbw_row_store) + int'(fbw_row_swap) + int'(frame_swap);
            if (fbw_wren) begin got = 1'b1; break; end
        end
        check("restart_wren_seen", 32'(got), 32'd1);
        check("restart_no_pulses", 32'(wcount), 32'd0);
        check("restart_pos", {20'd0, fbw_row_addr, fbw_col_addr}, 32'd0);
        check("restart_frame0_pix", 32'(fbw_data), 32'd0);

        // Animated vertical gradient, second frame.
        do_reset(2, 24'h0, 3'b111, 1'b1);
        wait_frame();
        wait_pixel(0, 0, d);
        check("vanim_r0", 32'(d), 32'(gam_pix(24'h080808)));
        wait_pixel(31, 5, d);
        check("vanim_r31", 32'(d), 32'(gam_pix(24'h000000)));
        wait_pixel(32, 3, d);
        check("vanim_r32", 32'(d), 32'(gam_pix(24'h080808)));
        wait_pixel(40, 63, d);
        check("vanim_r40", 32'(d), 32'(gam_pix(24'h484848)));

        // Mode change mid-frame only takes effect after the frame swap.
        do_reset(1, 24'h5A5A5A, 3'b111, 1'b0);
        wait_pixel(10, 0, d);
        #1 cfg_mode = 2'd3;
        wait_pixel(20, 8, d);
        check("midcfg_still_grad", 32'(d), 32'(gam_pix(24'h202020)));
        wait_frame();
        wait_pixel(0, 8, d);
        check("midcfg_check_on", 32'(d), 32'(gam_pix(24'h5A5A5A)));
        wait_pixel(1, 0, d);
        check("midcfg_check_off", 32'(d), 32'd0);

        // Random handshakes and mid-frame config churn, scored by the monitor.
        do_reset(int'($urandom_range(0, 3)), 24'($urandom), 3'($urandom), 1'b1);
        frames = 0;
        for (int i = 0; i < 40000 && frames < 3; i++) begin
            @(negedge clk);
            if (frame_swap) frames++;
            #1;
            fbw_row_rdy = ($urandom_range(0, 9) < 6);
            frame_rdy = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 499) == 0) begin
                cfg_mode = 2'($urandom);
                cfg_chan_mask = 3'($urandom);
                cfg_anim = 1'($urandom);
            end
        end
        check("random_frames_done", 32'(frames), 32'd3);
        fbw_row_rdy = 1'b1; frame_rdy = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
